// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a one-byte
// holding register presented through a sticky rdy/rdy_clr handshake.
module uart_rx_frame #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] data_out,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int TCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] TC_LAST = TCW'(DIV - 1);
  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic           rx_meta_q, rx_meta_d;
  logic           rx_s_q, rx_s_d;
  logic           rx_prev_q, rx_prev_d;
  logic [TCW-1:0] tc_q, tc_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [2:0]     bi_q, bi_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           rdy_q, rdy_d;
  logic           fe_q, fe_d;
  logic           ovr_q, ovr_d;
  logic           busy_q, busy_d;

  logic tick;
  logic fall;

  assign tick = (tc_q == TC_LAST);
  assign fall = rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d   = state_q;
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    tc_d      = tick ? '0 : tc_q + 1'b1;
    sc_d      = tick ? sc_q + 1'b1 : sc_q;
    bi_d      = bi_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rdy_d     = rdy_q;
    fe_d      = fe_q;
    ovr_d     = ovr_q;

    // Clear first so that a flag set in the same cycle takes priority.
    if (rdy_clr) begin
      rdy_d = 1'b0;
      fe_d  = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          tc_d    = '0;
          sc_d    = '0;
        end
      end
      START: begin
        if (tick && sc_q == SC_MID) begin
          if (!rx_s_q) begin
            state_d = DATA;
            sc_d    = '0;
            bi_d    = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && sc_q == SC_LAST) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bi_d    = bi_q + 3'd1;
          if (bi_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && sc_q == SC_LAST) begin
          state_d = IDLE;
          if (rx_s_q) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            if (rdy_q && !rdy_clr) ovr_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      tc_q      <= '0;
      sc_q      <= '0;
      bi_q      <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      rdy_q     <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      tc_q      <= tc_d;
      sc_q      <= sc_d;
      bi_q      <= bi_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out  = data_q;
  assign rdy       = rdy_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule
